cg_timer_ctrl: RTL and testbench
================================

// Module: cg_timer_ctrl
// PURPOSE
//  Control stage sitting directly upstream of the common free-running counter (o_count
//  width DATA_WIDTH): drives the counter's preset/stop/default inputs, watches its count,
//  and raises a one-cycle interrupt on compare match. Supports one-shot and periodic
//  timer modes, pause/resume and clear; turns the bare counter into a programmable timer.
// PARAMETERS
//  DATA_WIDTH   32  width of count, load and compare values (matches attached counter)
//  PRESC_WIDTH  8   width of prescale divisor (used only when CG_TIMER_PRESCALE_EN defined)
// PORTS
//  i_clk        in   1            clock
//  i_rstn       in   1            reset, asynchronous, active-low
//  i_start      in   1            pulse: load counter with i_load, latch config, enter RUN
//  i_halt       in   1            pulse: RUN -> PAUSED
//  i_resume     in   1            pulse: PAUSED -> RUN
//  i_clear      in   1            pulse: abort, preset counter to 0, enter IDLE
//  i_mode       in   1            0 = one-shot, 1 = periodic (latched on start)
//  i_load       in   DATA_WIDTH   start/reload value (latched on start)
//  i_compare    in   DATA_WIDTH   match value (latched on start)
//  i_count      in   DATA_WIDTH   current count fed back from counter
//  o_prst       out  1            counter preset (combinational)
//  o_stop       out  1            counter hold (combinational)
//  o_default    out  DATA_WIDTH   counter preset value (combinational)
//  o_irq        out  1            registered one-cycle pulse, cycle after match
//  o_state      out  2            current FSM state encoding
//  o_expiries   out  8            saturating count of matches since start/clear
// BEHAVIOUR
//  Reset: state IDLE, shadows (mode/load/compare) 0, o_irq 0, o_expiries 0.
//  While reset asserted, o_prst 0, o_stop 1, o_default 0.
//  FSM states: IDLE=0, RUN=1, PAUSED=2, DONE=3.
//  Priority per cycle: clear > start > match > halt > resume.
//  match = (state==RUN) && tick && (i_count == r_compare); tick is 1 when prescaling is absent.
//  start (any state): o_prst=1, o_default=i_load; at edge latch i_mode/i_load/i_compare,
//    clear o_expiries, state <= RUN; next cycle i_count == load.
//  RUN: o_stop = !tick.
//  RUN, periodic match: o_prst=1, o_default=r_load; count wraps to load.
//    Period = compare-load+1 cycles (mod 2^DATA_WIDTH).
//  RUN, one-shot match: o_stop=1, count holds at compare; state <= DONE.
//  On every match: o_irq=1 next cycle only; o_expiries += 1, saturating at 255.
//  halt same cycle as match: match fully applied; periodic -> PAUSED, one-shot -> DONE.
//  PAUSED/DONE/IDLE: o_stop=1. resume ignored outside PAUSED; halt ignored outside RUN.
//  clear: o_prst=1, o_default=0, state <= IDLE, o_expiries <= 0, pending o_irq suppressed.
//  compare < load: count runs through wrap at 2^DATA_WIDTH-1 -> 0 before matching.
//  Async reset mid-run: immediate return to reset values; counter is reset by the same i_rstn.
// CONFIGURATION
//  CG_TIMER_PRESCALE_EN defined: adds port i_presc [PRESC_WIDTH]; latched on start.
//    Prescale counter 0..presc; tick=1 only when prescale counter == presc.
//    Prescale counter resets to 0 on start/reload and freezes when not RUN.
//    Period = (compare-load+1)*(presc+1).
//  Undefined: no i_presc port, tick tied to 1, behaviour as above.
// STRUCTURE
//  cg_timer_pkg: typedef enum logic [1:0] timer_state_t {IDLE,RUN,PAUSED,DONE};
//    MODE_ONESHOT/MODE_PERIODIC localparams; EXPIRY_MAX = 8'd255.
//  Sub-module cg_prescaler (PRESC_WIDTH, i_clk, i_rstn, i_en, i_restart, i_div, o_tick)
//    is instantiated only under CG_TIMER_PRESCALE_EN.
//  Bench instantiates CG_counter downstream in a closed loop.
// TESTING
//  1 periodic L=0,C=3, start -> count 0,1,2,3,0,...; o_irq every 4 cycles; o_expiries 1,2,3.
//  2 one-shot L=10,C=12 -> irq once, count holds 12, o_state=3; later start re-arms to 10.
//  3 halt at count 5 (L=0,C=9); wait 7 cycles; resume -> count stays 5 while PAUSED,
//    irq fires 5 cycles after resume.
//  4 clear and start same cycle -> IDLE, count 0, no irq; start+halt same cycle -> RUN.
//  5 L=2^DW-2, C=1 periodic -> wraps through 0, match after 4 cycles; 300 matches
//    -> o_expiries=255.
//  6 (PRESCALE_EN) presc=2, L=0, C=1 -> each count value held 3 cycles, irq every 6 cycles.

Source files
------------

// File: rtl/cg_timer_pkg.sv
// cg_timer_pkg: shared state encoding, mode codes and expiry limit for the timer control stage
package cg_timer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        DONE   = 2'd3
    } timer_state_t;

    localparam logic       MODE_ONESHOT  = 1'b0;
    localparam logic       MODE_PERIODIC = 1'b1;
    localparam logic [7:0] EXPIRY_MAX    = 8'd255;

endpackage

// File: rtl/cg_timer_ctrl_prescaler.sv
// cg_prescaler: divides the run clock into one tick every i_div+1 enabled cycles
module cg_prescaler #(
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_en,
    input  logic                   i_restart,
    input  logic [PRESC_WIDTH-1:0] i_div,
    output logic                   o_tick
);

    logic [PRESC_WIDTH-1:0] r_cnt;

    assign o_tick = r_cnt == i_div;

    // count 0..i_div while enabled, restart from 0 on start/reload, freeze otherwise
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_cnt <= '0;
        else if (i_restart)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/cg_timer_ctrl.sv
// cg_timer_ctrl: timer control for a free-running counter; prescaler optional via CG_TIMER_PRESCALE_EN
module cg_timer_ctrl
    import cg_timer_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_start,
    input  logic                  i_halt,
    input  logic                  i_resume,
    input  logic                  i_clear,
    input  logic                  i_mode,
    input  logic [DATA_WIDTH-1:0] i_load,
    input  logic [DATA_WIDTH-1:0] i_compare,
    input  logic [DATA_WIDTH-1:0] i_count,
`ifdef CG_TIMER_PRESCALE_EN
    input  logic [PRESC_WIDTH-1:0] i_presc,
`endif
    output logic                  o_prst,
    output logic                  o_stop,
    output logic [DATA_WIDTH-1:0] o_default,
    output logic                  o_irq,
    output logic [1:0]            o_state,
    output logic [7:0]            o_expiries
);

    timer_state_t          r_state, state_d;
    logic                  r_mode;
    logic [DATA_WIDTH-1:0] r_load, r_compare, dflt;
    logic [7:0]            r_exp;
    logic                  r_irq, irq_d, tick, match, prst, stop;

`ifdef CG_TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] r_presc;

    // divisor is captured with the rest of the configuration on start
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_presc <= '0;
        else if (!i_clear && i_start)
            r_presc <= i_presc;
    end

    cg_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_prescaler (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_en      (r_state == RUN),
        .i_restart (i_clear || i_start || (match && r_mode == MODE_PERIODIC)),
        .i_div     (r_presc),
        .o_tick    (tick)
    );
`else
    assign tick = 1'b1;
`endif

    assign match = r_state == RUN && tick && i_count == r_compare;

    // next state and counter controls, priority clear > start > match > halt > resume
    always_comb begin
        state_d = r_state;
        prst    = 1'b0;
        stop    = 1'b1;
        dflt    = '0;
        irq_d   = 1'b0;
        if (i_clear) begin
            prst    = 1'b1;
            state_d = IDLE;
        end else if (i_start) begin
            prst    = 1'b1;
            dflt    = i_load;
            state_d = RUN;
        end else if (match) begin
            irq_d = 1'b1;
            if (r_mode == MODE_PERIODIC) begin
                prst    = 1'b1;
                dflt    = r_load;
                state_d = i_halt ? PAUSED : RUN;
            end else
                state_d = DONE;
        end else if (r_state == RUN) begin
            stop    = !tick;
            state_d = i_halt ? PAUSED : RUN;
        end else if (r_state == PAUSED && i_resume)
            state_d = RUN;
    end

    // state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn)
            r_state <= IDLE;
        else
            r_state <= state_d;
    end

    // configuration shadows, interrupt pulse and saturating expiry count
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_mode    <= MODE_ONESHOT;
            r_load    <= '0;
            r_compare <= '0;
            r_irq     <= 1'b0;
            r_exp     <= '0;
        end else begin
            r_irq <= irq_d;
            if (i_clear)
                r_exp <= '0;
            else if (i_start) begin
                r_mode    <= i_mode;
                r_load    <= i_load;
                r_compare <= i_compare;
                r_exp     <= '0;
            end else if (match && r_exp != EXPIRY_MAX)
                r_exp <= r_exp + 8'd1;
        end
    end

    assign o_prst     = i_rstn && prst;
    assign o_stop     = !i_rstn || stop;
    assign o_default  = i_rstn ? dflt : '0;
    assign o_irq      = r_irq;
    assign o_state    = r_state;
    assign o_expiries = r_exp;

endmodule

// File: tb/tb_cg_timer_ctrl.sv
// tb_cg_timer_ctrl: closed-loop bench with a free-running counter model and an expectation queue
module tb_cg_timer_ctrl;

    localparam int DW = 32;

    typedef struct packed {
        logic [DW-1:0] cnt;
        logic          irq;
        logic [1:0]    st;
        logic [7:0]    ex;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn, start, halt, resume, clear, mode;
    logic [DW-1:0] load, cmp, count, dflt;
    logic          prst, stop, irq;
    logic [1:0]    state;
    logic [7:0]    expiries;
    logic [7:0]    presc;
    int            n_chk = 0;
    int            n_fail = 0;
    exp_t          sb[$];
    exp_t          e;

    cg_timer_ctrl #(.DATA_WIDTH(DW), .PRESC_WIDTH(8)) dut (
        .i_clk      (clk),
        .i_rstn     (rstn),
        .i_start    (start),
        .i_halt     (halt),
        .i_resume   (resume),
        .i_clear    (clear),
        .i_mode     (mode),
        .i_load     (load),
        .i_compare  (cmp),
        .i_count    (count),
`ifdef CG_TIMER_PRESCALE_EN
        .i_presc    (presc),
`endif
        .o_prst     (prst),
        .o_stop     (stop),
        .o_default  (dflt),
        .o_irq      (irq),
        .o_state    (state),
        .o_expiries (expiries)
    );

    always #5 clk = ~clk;

    // downstream free-running counter: preset wins over hold
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            count <= '0;
        else if (prst)
            count <= dflt;
        else if (!stop)
            count <= count + 1'b1;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic m, input logic [DW-1:0] l, input logic [DW-1:0] c);
        mode  = m;
        load  = l;
        cmp   = c;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b1; halt = 1'b0; resume = 1'b0; clear = 1'b0;
        mode = 1'b1; load = 32'd5; cmp = 32'd9; presc = 8'd0;
        #23;
        n_chk += 7;
        if (state !== 2'd0) begin n_fail++; $display("FAIL reset_state got %0d exp 0", state); end
        if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq got %0b exp 0", irq); end
        if (expiries !== 8'd0) begin n_fail++; $display("FAIL reset_exp got %0d exp 0", expiries); end
        if (prst !== 1'b0) begin n_fail++; $display("FAIL reset_prst got %0b exp 0", prst); end
        if (stop !== 1'b1) begin n_fail++; $display("FAIL reset_stop got %0b exp 1", stop); end
        if (dflt !== '0) begin n_fail++; $display("FAIL reset_default got %0h exp 0", dflt); end
        if (count !== '0) begin n_fail++; $display("FAIL reset_count got %0h exp 0", count); end
        start = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
    endtask

    task automatic test_periodic();
        do_start(1'b1, 32'd0, 32'd3);
        for (int k = 0; k < 13; k++) begin
            resume = (k == 2);
            sb.push_back(exp_t'{DW'(k % 4), k > 0 && k % 4 == 0, 2'd1, 8'(k / 4)});
            @(negedge clk);
            e = sb.pop_front();
            n_chk += 4;
            if (count !== e.cnt) begin n_fail++; $display("FAIL periodic_count k=%0d got %0h exp %0h", k, count, e.cnt); end
            if (irq !== e.irq) begin n_fail++; $display("FAIL periodic_irq k=%0d got %0b exp %0b", k, irq, e.irq); end
            if (state !== e.st) begin n_fail++; $display("FAIL periodic_state k=%0d got %0d exp %0d", k, state, e.st); end
            if (expiries !== e.ex) begin n_fail++; $display("FAIL periodic_exp k=%0d got %0d exp %0d", k, expiries, e.ex); end
            next_cycle();
        end
        resume = 1'b0;
    endtask

    task automatic test_oneshot();
        do_start(1'b0, 32'd10, 32'd12);
        for (int k = 0; k < 9; k++) begin
            halt   = (k == 4);
            resume = (k == 5);
            start  = (k == 6);
            sb.push_back(exp_t'{k < 2 ? DW'(10 + k) : (k <= 6 ? DW'(12) : DW'(10 + k - 7)),
                                k == 3, (k >= 3 && k <= 6) ? 2'd3 : 2'd1, 8'(k >= 3 && k <= 6)});
            @(negedge clk);
            e = sb.pop_front();
            n_chk += 4;
            if (count !== e.cnt) begin n_fail++; $display("FAIL oneshot_count k=%0d got %0h exp %0h", k, count, e.cnt); end
            if (irq !== e.irq) begin n_fail++; $display("FAIL oneshot_irq k=%0d got %0b exp %0b", k, irq, e.irq); end
            if (state !== e.st) begin n_fail++; $display("FAIL oneshot_state k=%0d got %0d exp %0d", k, state, e.st); end
            if (expiries !== e.ex) begin n_fail++; $display("FAIL oneshot_exp k=%0d got %0d exp %0d", k, expiries, e.ex); end
            if (k == 6) begin
                n_chk++;
                if (prst !== 1'b1 || dflt !== 32'd10) begin
                    n_fail++; $display("FAIL oneshot_rearm_preset got prst=%0b default=%0h exp prst=1 default=a", prst, dflt);
                end
            end
            next_cycle();
        end
        halt = 1'b0; resume = 1'b0; start = 1'b0;
    endtask

    task automatic test_halt_resume();
        do_start(1'b1, 32'd0, 32'd9);
        for (int k = 0; k < 19; k++) begin
            halt   = (k == 4);
            resume = (k == 11);
            sb.push_back(exp_t'{k <= 4 ? DW'(k) : (k <= 11 ? DW'(5) : (k <= 16 ? DW'(k - 7) : DW'(k - 17))),
                                k == 17, (k >= 5 && k <= 11) ? 2'd2 : 2'd1, 8'(k >= 17)});
            @(negedge clk);
            e = sb.pop_front();
            n_chk += 4;
            if (count !== e.cnt) begin n_fail++; $display("FAIL halt_count k=%0d got %0h exp %0h", k, count, e.cnt); end
            if (irq !== e.irq) begin n_fail++; $display("FAIL halt_irq k=%0d got %0b exp %0b", k, irq, e.irq); end
            if (state !== e.st) begin n_fail++; $display("FAIL halt_state k=%0d got %0d exp %0d", k, state, e.st); end
            if (expiries !== e.ex) begin n_fail++; $display("FAIL halt_exp k=%0d got %0d exp %0d", k, expiries, e.ex); end
            next_cycle();
        end
        halt = 1'b0; resume = 1'b0;
    endtask

    task automatic test_priority();
        do_start(1'b1, 32'd5, 32'd7);
        for (int k = 0; k < 8; k++) begin
            clear = (k == 2);
            start = (k == 2 || k == 4);
            halt  = (k == 4);
            sb.push_back(exp_t'{k <= 2 ? DW'(5 + k) : (k <= 4 ? DW'(0) : DW'(k)),
                                1'b0, (k == 3 || k == 4) ? 2'd0 : 2'd1, 8'd0});
            @(negedge clk);
            e = sb.pop_front();
            n_chk += 4;
            if (count !== e.cnt) begin n_fail++; $display("FAIL prio_count k=%0d got %0h exp %0h", k, count, e.cnt); end
            if (irq !== e.irq) begin n_fail++; $display("FAIL prio_irq k=%0d got %0b exp %0b", k, irq, e.irq); end
            if (state !== e.st) begin n_fail++; $display("FAIL prio_state k=%0d got %0d exp %0d", k, state, e.st); end
            if (expiries !== e.ex) begin n_fail++; $display("FAIL prio_exp k=%0d got %0d exp %0d", k, expiries, e.ex); end
            next_cycle();
        end
        clear = 1'b0; start = 1'b0; halt = 1'b0;
    endtask

    task automatic test_wrap_saturate();
        do_start(1'b1, 32'hFFFF_FFFE, 32'd1);
        for (int k = 0; k < 1204; k++) begin
            sb.push_back(exp_t'{32'hFFFF_FFFE + DW'(k % 4), k > 0 && k % 4 == 0, 2'd1,
                                k / 4 > 255 ? 8'd255 : 8'(k / 4)});
            @(negedge clk);
            e = sb.pop_front();
            n_chk += 4;
            if (count !== e.cnt) begin n_fail++; $display("FAIL wrap_count k=%0d got %0h exp %0h", k, count, e.cnt); end
            if (irq !== e.irq) begin n_fail++; $display("FAIL wrap_irq k=%0d got %0b exp %0b", k, irq, e.irq); end
            if (state !== e.st) begin n_fail++; $display("FAIL wrap_state k=%0d got %0d exp %0d", k, state, e.st); end
            if (expiries !== e.ex) begin n_fail++; $display("FAIL wrap_exp k=%0d got %0d exp %0d", k, expiries, e.ex); end
            next_cycle();
        end
    endtask

`ifdef CG_TIMER_PRESCALE_EN
    task automatic test_prescale();
        presc = 8'd2;
        do_start(1'b1, 32'd0, 32'd1);
        for (int k = 0; k < 19; k++) begin
            sb.push_back(exp_t'{DW'((k / 3) % 2), k > 0 && k % 6 == 0, 2'd1, 8'(k / 6)});
            @(negedge clk);
            e = sb.pop_front();
            n_chk += 4;
            if (count !== e.cnt) begin n_fail++; $display("FAIL presc_count k=%0d got %0h exp %0h", k, count, e.cnt); end
            if (irq !== e.irq) begin n_fail++; $display("FAIL presc_irq k=%0d got %0b exp %0b", k, irq, e.irq); end
            if (state !== e.st) begin n_fail++; $display("FAIL presc_state k=%0d got %0d exp %0d", k, state, e.st); end
            if (expiries !== e.ex) begin n_fail++; $display("FAIL presc_exp k=%0d got %0d exp %0d", k, expiries, e.ex); end
            next_cycle();
        end
        presc = 8'd0;
    endtask
`endif

    task automatic test_async_reset();
        do_start(1'b1, 32'd0, 32'd3);
        repeat (6) next_cycle();
        #2;
        rstn = 1'b0;
        #1;
        n_chk += 5;
        if (count !== '0) begin n_fail++; $display("FAIL areset_count got %0h exp 0", count); end
        if (state !== 2'd0) begin n_fail++; $display("FAIL areset_state got %0d exp 0", state); end
        if (expiries !== 8'd0) begin n_fail++; $display("FAIL areset_exp got %0d exp 0", expiries); end
        if (irq !== 1'b0) begin n_fail++; $display("FAIL areset_irq got %0b exp 0", irq); end
        if (stop !== 1'b1) begin n_fail++; $display("FAIL areset_stop got %0b exp 1", stop); end
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_oneshot();
        test_halt_resume();
        test_priority();
        test_wrap_saturate();
`ifdef CG_TIMER_PRESCALE_EN
        test_prescale();
`endif
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
